// File: rtl/dff_4bit.sv
// Parameterised D-type register: q takes d on every rising clk edge, or
// RESET_VAL when the synchronous active-high reset is sampled high.
module dff_4bit #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_dff_4bit.sv
// Self-checking bench for dff_4bit: directed reset/latency/glitch cases plus
// an exhaustive sweep and a randomized run checked against a rule-level model.
module tb_dff_4bit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d;
    logic [3:0] q;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [3:0] RST_VAL = 4'h0;

    dff_4bit #(
        .WIDTH     (4),
        .RESET_VAL (RST_VAL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: q=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Predict q from the inputs presented at the coming edge, take the edge,
    // then compare 1 time unit later.
    task automatic tick(input string tag);
        logic [3:0] exp;
        exp = reset ? RST_VAL : d;
        @(posedge clk);
        #1;
        check(tag, q, exp);
    endtask

    initial begin
        logic [3:0] held;
        logic [3:0] seq [4];
        logic [3:0] exp_q;

        reset = 1'b1;
        d     = 4'hF;

        // Reset for two edges with d=F: q stays at the reset value.
        tick("reset_edge1");
        tick("reset_edge2");

        // Successive values appear one edge later, in order.
        reset  = 1'b0;
        seq[0] = 4'h3; seq[1] = 4'hA; seq[2] = 4'h5; seq[3] = 4'hC;
        for (int i = 0; i < 4; i++) begin
            d = seq[i];
            tick("sequence");
        end

        // d glitches between edges; only the value present at the edge counts.
        held = q;
        d = 4'h1;
        #2;
        check("glitch_hold_a", q, held);
        d = 4'h6;
        #2;
        check("glitch_hold_b", q, held);
        d = 4'h9;
        tick("glitch_capture");

        // Reset raised mid-cycle: q holds until the edge, then clears.
        d = 4'h7;
        tick("pre_reset_load");
        #3;
        reset = 1'b1;
        d     = 4'hB;
        #1;
        check("midcycle_reset_hold", q, 4'h7);
        tick("reset_wins");
        tick("reset_held");

        // Release with d=E held: loads on the first edge, no recovery cycle.
        d = 4'hE;
        #2;
        reset = 1'b0;
        #1;
        check("release_before_edge", q, RST_VAL);
        tick("release_load");

        // Exhaustive sweep of every d value.
        for (int v = 0; v < 16; v++) begin
            d = 4'(v);
            tick("exhaustive");
        end

        // Randomized d with occasional reset pulses; model is the plain rule
        // "q after an edge = reset ? RST_VAL : d", and q must not move between edges.
        for (int n = 0; n < 200; n++) begin
            reset = ($urandom_range(0, 7) == 0);
            d     = 4'($urandom);
            exp_q = q;
            #2;
            d = 4'($urandom);
            check("random_between_edges", q, exp_q);
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
